button_event_fsm: RTL and testbench



---
 rtl/button_event_fsm.sv | 151 +++++++++++++++
 tb/tb_button_event_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_fsm.sv
// Turns a debounced, clk-synchronous button level into press/short/long event pulses.
// Define BUTTON_AUTO_REPEAT_EN to build the auto-repeat counter that drives repeat_pulse.
module button_event_fsm #(
  parameter int unsigned LONG_CYCLES   = 100_000_000,
  parameter int unsigned REPEAT_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_e;

  localparam int unsigned     CNT_W     = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("button_event_fsm: LONG_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("button_event_fsm: REPEAT_CYCLES must be >= 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             btn_q;
  logic             rise;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             held_q, held_d;

  assign rise = btn_in & ~btn_q;

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = HELD;
          hold_cnt_d = CNT_W'(1);
          press_d    = 1'b1;
        end
      end
      HELD: begin
        if (btn_in) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
          if (hold_cnt_q == LONG_LAST) begin
            state_d = LONG;
            long_d  = 1'b1;
          end
        end else begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          short_d    = 1'b1;
        end
      end
      LONG: begin
        // Counter sits at LONG_MAX for the rest of the hold; it never wraps.
        hold_cnt_d = LONG_MAX;
        if (!btn_in) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned      REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             repeat_q, repeat_d;

  // Runs only while a long hold lasts; the entry cycle (long_pulse) is count 0.
  always_comb begin
    rep_cnt_d = '0;
    repeat_d  = 1'b0;
    if (state_q == LONG && btn_in) begin
      if (rep_cnt_q == REP_LAST) begin
        repeat_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      // Starts high so a button held through reset must be seen low before it counts.
      btn_q      <= 1'b1;
      press_q    <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_q  <= '0;
      repeat_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      btn_q      <= btn_in;
      press_q    <= press_d;
      short_q    <= short_d;
      long_q     <= long_d;
      held_q     <= held_d;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
      repeat_q   <= repeat_d;
`endif
    end
  end

  assign press_pulse = press_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign held        = held_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Scoreboard bench for button_event_fsm (LONG_CYCLES=8, REPEAT_CYCLES=4); stimulus
// pushes expected pulses with the edge they must appear on, a monitor pops and compares.
module tb_button_event_fsm;

  localparam int LONG_C = 8;
  localparam int REP_C  = 4;

  typedef enum int {EV_PRESS = 0, EV_SHORT = 1, EV_LONG = 2, EV_REPEAT = 3} ev_e;
  typedef struct {
    ev_e kind;
    int  edge_no;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_in = 1'b0;
  logic press_pulse, short_pulse, long_pulse, repeat_pulse, held;

  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;
  ev_t  exp_q[$];

  button_event_fsm #(
    .LONG_CYCLES  (LONG_C),
    .REPEAT_CYCLES(REP_C)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_in      (btn_in),
    .press_pulse (press_pulse),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edges);
    end
  endtask

  // Monitor: every visible pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [3:0] p;
    ev_e        k;
    ev_t        e;
    p = {repeat_pulse, long_pulse, short_pulse, press_pulse};
    if (p != 4'b0) begin
      check("pulse_onehot", $countones(p), 1);
      if (p[0])      k = EV_PRESS;
      else if (p[1]) k = EV_SHORT;
      else if (p[2]) k = EV_LONG;
      else           k = EV_REPEAT;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d at edge %0d, expected none", int'(k), edges);
      end else begin
        e = exp_q.pop_front();
        check("ev_kind", int'(k), int'(e.kind));
        check("ev_edge", edges, e.edge_no);
      end
    end
  end

  task automatic expect_ev(input ev_e kind, input int base, input int offset);
    ev_t e;
    e.kind    = kind;
    e.edge_no = base + offset;
    exp_q.push_back(e);
  endtask

  // Hold btn_in at b across n rising edges, returning just after the last one.
  task automatic drive(input logic b, input int n);
    btn_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_press"},  int'(press_pulse),  0);
    check({tag, "_short"},  int'(short_pulse),  0);
    check({tag, "_long"},   int'(long_pulse),   0);
    check({tag, "_repeat"}, int'(repeat_pulse), 0);
    check({tag, "_held"},   int'(held),         0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_missing_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Expectations for one press of n_high samples followed by n_low low samples.
  task automatic hold_and_release(input int n_high, input int n_low);
    int base;
    base = edges;
    expect_ev(EV_PRESS, base, 1);
    if (n_high < LONG_C) begin
      expect_ev(EV_SHORT, base, n_high + 1);
    end else begin
      expect_ev(EV_LONG, base, LONG_C);
`ifdef BUTTON_AUTO_REPEAT_EN
      for (int t = LONG_C + REP_C; t <= n_high; t += REP_C) expect_ev(EV_REPEAT, base, t);
`endif
    end
    drive(1'b1, n_high);
    drive(1'b0, n_low);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 2);

    // 1: three-cycle press.
    base = edges;
    expect_ev(EV_PRESS, base, 1);
    expect_ev(EV_SHORT, base, 4);
    drive(1'b1, 3);
    check("t1_held_during", int'(held), 1);
    drive(1'b0, 3);
    check("t1_held_after", int'(held), 0);
    check_drained("t1");

    // 2a: seven high samples is still short.
    base = edges;
    expect_ev(EV_PRESS, base, 1);
    expect_ev(EV_SHORT, base, 8);
    drive(1'b1, 7);
    drive(1'b0, 3);
    check_drained("t2a");

    // 2b: eight high samples is long, no short on release.
    base = edges;
    expect_ev(EV_PRESS, base, 1);
    expect_ev(EV_LONG, base, 8);
    drive(1'b1, 8);
    check("t2b_held_long", int'(held), 1);
    drive(1'b0, 4);
    check("t2b_held_after", int'(held), 0);
    check_drained("t2b");

    // 3: twenty-cycle hold, repeats only with the macro.
    base = edges;
    expect_ev(EV_PRESS, base, 1);
    expect_ev(EV_LONG, base, 8);
`ifdef BUTTON_AUTO_REPEAT_EN
    expect_ev(EV_REPEAT, base, 12);
    expect_ev(EV_REPEAT, base, 16);
    expect_ev(EV_REPEAT, base, 20);
`endif
    drive(1'b1, 20);
    drive(1'b0, 8);
    check_drained("t3");

    // 4: button held through reset produces nothing until seen low.
    btn_in = 1'b1;
    #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("t4_in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 5);
    check("t4_held_after_reset", int'(held), 0);
    check_drained("t4_quiet");
    base = edges;
    expect_ev(EV_PRESS, base, 2);
    expect_ev(EV_SHORT, base, 4);
    drive(1'b0, 1);
    drive(1'b1, 2);
    drive(1'b0, 3);
    check_drained("t4");

    // 5: reset at hold cycle 5 discards the pending pulse.
    base = edges;
    expect_ev(EV_PRESS, base, 1);
    drive(1'b1, 5);
    check("t5_held_before", int'(held), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("t5_async");
    btn_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 12);
    check_idle("t5_after");
    check_drained("t5");

    // 6: pseudo-random press lengths and gaps.
    for (int i = 0; i < 400; i++) begin
      hold_and_release(int'($urandom_range(1, 14)), int'($urandom_range(1, 4)));
    end
    drive(1'b0, 4);
    check_drained("t6");
    check_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
